mix_columns_seq: RTL and testbench
==================================

// Module: mix_columns_seq
// PURPOSE
//  Sequential, parametrised AES (Inv)MixColumns engine with valid/ready handshake on both sides.
//  Processes one 128-bit state over 4/COLS_PER_CYCLE cycles, trading area for latency.
//  Forward mode serves the encrypt round datapath; inverse mode serves the decrypt round datapath.
//  Sits between the ShiftRows/InvShiftRows stage and the AddRoundKey stage of the round controller.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per cycle; legal values 1, 2 and 4; any other value is an elaboration error
//  INV_EN          1  1 = inverse datapath built; 0 = forward only, in_inverse ignored
// PORTS
//  clk         in   1    single clock, rising edge
//  rst_n       in   1    synchronous reset, active-low
//  in_valid    in   1    state_in/in_inverse valid
//  in_ready    out  1    engine can accept a state
//  in_inverse  in   1    0 = MixColumns, 1 = InvMixColumns (requires INV_EN=1)
//  state_in    in   128  input state; column c = [c*32+:32]; row0 byte = [c*32+24+:8], row3 byte = [c*32+:8]
//  out_valid   out  1    state_out holds a completed result
//  out_ready   in   1    downstream accepts result
//  state_out   out  128  result, same byte mapping as state_in
//  busy        out  1    high in BUSY and DONE
// BEHAVIOUR
//  Reset (rst_n=0 at rising clk): FSM->IDLE, col counter=0, out_valid=0, state_out=0, busy=0, in_ready=0 in the reset cycle.
//  FSM:
//   IDLE: in_ready=1. in_valid&in_ready at edge -> capture state_in into work reg and latch mode (in_inverse&INV_EN), col=0 -> BUSY.
//   BUSY: in_ready=0. Each cycle, transform columns col..col+COLS_PER_CYCLE-1 of work reg in place; col+=COLS_PER_CYCLE.
//         Column order: column 0 (bits 31:0) first, column 3 last.
//         On the edge that processes column 3: state_out <= final work reg, out_valid<=1 -> DONE; col wraps to 0.
//   DONE: out_valid=1, in_ready=0. out_valid&out_ready at edge -> out_valid<=0 -> IDLE.
//         state_out and out_valid stable while out_ready=0 (no timeout).
//  Latency: accept edge = cycle 0; out_valid first high after edge 4/COLS_PER_CYCLE (4, 2 or 1 cycles).
//  Throughput: one state per 4/COLS_PER_CYCLE+2 cycles when out_ready held high; no accept while BUSY/DONE.
//  Forward column (a0..a3 = rows 0..3): b_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
//  Inverse column: b_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3).
//  GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (xtime: shift left, xor 8'h1b when bit7 set); all products 8-bit, no carries.
//  Mode is latched at accept; in_inverse changes during BUSY/DONE have no effect.
//  in_inverse=1 with INV_EN=0: forward transform performed, no error flag.
//  state_in changes after accept have no effect; work reg is the only source.
//  state_out keeps last result after the DONE handshake until the next completion (content undefined for checking when out_valid=0).
//  Reset mid-operation (BUSY or DONE): partial/unconsumed result discarded, outputs to reset values; next accept starts clean.
//  in_valid deasserted in IDLE: stay in IDLE, no register updates.
// TESTING
//  T1 forward, COLS_PER_CYCLE=1: state_in=db135345_f20a225c_01010101_2d26314c, in_inverse=0 -> after 4 cycles
//     out_valid=1, state_out=8e4da1bc_9fdc589d_01010101_4d7ebdf8.
//  T2 inverse: state_in=8e4da1bc_9fdc589d_01010101_4d7ebdf8, in_inverse=1 -> state_out=db135345_f20a225c_01010101_2d26314c.
//  T3 backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, state_out stable, in_ready=0; in_valid ignored.
//  T4 repeat T1 with COLS_PER_CYCLE=2 and 4 -> identical result at latency 2 and 1; back-to-back states with out_ready=1
//     -> accepts spaced exactly 4/COLS_PER_CYCLE+2 cycles.
//  T5 reset: assert rst_n=0 during BUSY cycle 2 -> next edge out_valid=0, state_out=0, busy=0; new T1 transaction then correct.
//  T6 mode latch/INV_EN: toggle in_inverse during BUSY -> result per accept-time mode; INV_EN=0 with in_inverse=1 -> T1 forward result.

Source files
------------

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine.
// A 128-bit state is captured into a work register and transformed in place,
// COLS_PER_CYCLE columns per clock (column 0 first). The result is held on
// state_out with out_valid until the downstream stage accepts it.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inverse,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  // Reject unsupported column widths at elaboration time.
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  // Column index that finishes the state, and the counter increment.
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic         inv_q, inv_d;
  logic [127:0] work_q, work_d;
  logic [127:0] sout_q, sout_d;
  logic [127:0] xf;
  logic         accept, last;

  // GF(2^8) multiply by x, reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One output row: forward uses {2,3,1,1}, inverse uses {0e,0b,0d,09}
  // applied to rows r, r+1, r+2, r+3.
  function automatic logic [7:0] mix_row(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3,
                                         input logic inv);
    logic [7:0] a0x2, a0x4, a0x8, a1x2, a1x4, a1x8, a2x2, a2x4, a2x8, a3x2, a3x4, a3x8;
    a0x2 = xtime(a0); a0x4 = xtime(a0x2); a0x8 = xtime(a0x4);
    a1x2 = xtime(a1); a1x4 = xtime(a1x2); a1x8 = xtime(a1x4);
    a2x2 = xtime(a2); a2x4 = xtime(a2x2); a2x8 = xtime(a2x4);
    a3x2 = xtime(a3); a3x4 = xtime(a3x2); a3x8 = xtime(a3x4);
    if (inv)
      mix_row = (a0x8 ^ a0x4 ^ a0x2) ^ (a1x8 ^ a1x2 ^ a1) ^ (a2x8 ^ a2x4 ^ a2) ^ (a3x8 ^ a3);
    else
      mix_row = a0x2 ^ (a1x2 ^ a1) ^ a2 ^ a3;
  endfunction

  // Full column transform; row 0 sits in the top byte.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0] r0, r1, r2, r3;
    r0 = c[31:24]; r1 = c[23:16]; r2 = c[15:8]; r3 = c[7:0];
    mix_col = {mix_row(r0, r1, r2, r3, inv), mix_row(r1, r2, r3, r0, inv),
               mix_row(r2, r3, r0, r1, inv), mix_row(r3, r0, r1, r2, inv)};
  endfunction

  assign accept = (state_q == IDLE) && in_valid;
  assign last   = (state_q == BUSY) && (col_q == LAST_COL);

  // Work register with the current group of columns transformed.
  always_comb begin
    xf = work_q;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      xf[{col_q + 2'(j), 5'd0} +: 32] = mix_col(work_q[{col_q + 2'(j), 5'd0} +: 32], inv_q);
    end
  end

  // Next-state logic for the control FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath next values: capture on accept, step columns while busy.
  always_comb begin
    col_d  = col_q;
    inv_d  = inv_q;
    work_d = work_q;
    sout_d = sout_q;
    if (accept) begin
      work_d = state_in;
      inv_d  = in_inverse & INV_EN;
      col_d  = 2'd0;
    end else if (state_q == BUSY) begin
      work_d = xf;
      if (last) begin
        sout_d = xf;
        col_d  = 2'd0;
      end else begin
        col_d  = col_q + STEP;
      end
    end
  end

  // Handshake and status outputs decoded from the FSM state.
  always_comb begin
    in_ready  = rst_n && (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    state_out = sout_q;
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      inv_q   <= 1'b0;
      sout_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      inv_q   <= inv_d;
      sout_q  <= sout_d;
    end
  end

  // Work register is overwritten on every accept, so it needs no reset.
  always_ff @(posedge clk) begin
    work_q <= work_d;
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: four instances (1, 2 and 4 columns per cycle,
// plus a forward-only build) share one set of inputs.
module tb_mix_columns_seq;

  localparam logic [127:0] PT = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] MC = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_inverse, out_ready;
  logic [127:0] state_in;
  logic         ir [4];
  logic         ov [4];
  logic         bz [4];
  logic [127:0] so [4];

  int checks = 0;
  int errors = 0;
  int lat [4] = '{4, 2, 1, 4};

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_inverse(in_inverse),
    .state_in(state_in), .out_valid(ov[0]), .out_ready(out_ready), .state_out(so[0]), .busy(bz[0]));
  mix_columns_seq #(.COLS_PER_CYCLE(2), .INV_EN(1'b1)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_inverse(in_inverse),
    .state_in(state_in), .out_valid(ov[1]), .out_ready(out_ready), .state_out(so[1]), .busy(bz[1]));
  mix_columns_seq #(.COLS_PER_CYCLE(4), .INV_EN(1'b1)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_inverse(in_inverse),
    .state_in(state_in), .out_valid(ov[2]), .out_ready(out_ready), .state_out(so[2]), .busy(bz[2]));
  mix_columns_seq #(.COLS_PER_CYCLE(1), .INV_EN(1'b0)) u_fwd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .in_inverse(in_inverse),
    .state_in(state_in), .out_valid(ov[3]), .out_ready(out_ready), .state_out(so[3]), .busy(bz[3]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one state for a single cycle; returns #1 after the accept edge.
  task automatic start(input logic [127:0] s, input logic inv);
    state_in   = s;
    in_inverse = inv;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    state_in   = ~s;
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inverse = 1'b0; state_in = '0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (ov[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", i, ov[i]); end
      checks++; if (so[i] !== 128'h0) begin errors++; $display("FAIL reset_state_out[%0d]: got %h expected 0", i, so[i]); end
      checks++; if (bz[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, bz[i]); end
      checks++; if (ir[i] !== 1'b0) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 0", i, ir[i]); end
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (ir[i] !== 1'b1) begin errors++; $display("FAIL idle_in_ready[%0d]: got %b expected 1", i, ir[i]); end
    end
  endtask

  task automatic test_forward;
    logic exp_v;
    out_ready = 1'b0;
    start(PT, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        exp_v = (k >= lat[i]);
        checks++; if (ov[i] !== exp_v) begin errors++; $display("FAIL fwd_latency[%0d] edge %0d: got %b expected %b", i, k, ov[i], exp_v); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (so[i] !== MC) begin errors++; $display("FAIL fwd_result[%0d]: got %h expected %h", i, so[i], MC); end
      checks++; if (bz[i] !== 1'b1) begin errors++; $display("FAIL done_busy[%0d]: got %b expected 1", i, bz[i]); end
      checks++; if (ir[i] !== 1'b0) begin errors++; $display("FAIL done_in_ready[%0d]: got %b expected 0", i, ir[i]); end
    end
    release_out();
    for (int i = 0; i < 4; i++) begin
      checks++; if (ov[i] !== 1'b0) begin errors++; $display("FAIL handshake_out_valid[%0d]: got %b expected 0", i, ov[i]); end
      checks++; if (ir[i] !== 1'b1) begin errors++; $display("FAIL handshake_in_ready[%0d]: got %b expected 1", i, ir[i]); end
      checks++; if (bz[i] !== 1'b0) begin errors++; $display("FAIL handshake_busy[%0d]: got %b expected 0", i, bz[i]); end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    start(PT, 1'b0);
    repeat (4) tick();
    in_valid = 1'b1; state_in = MC; in_inverse = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        checks++; if (ov[i] !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] cyc %0d: got %b expected 1", i, n, ov[i]); end
        checks++; if (so[i] !== MC) begin errors++; $display("FAIL bp_state_out[%0d] cyc %0d: got %h expected %h", i, n, so[i], MC); end
        checks++; if (ir[i] !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] cyc %0d: got %b expected 0", i, n, ir[i]); end
      end
    end
    in_valid = 1'b0;
    release_out();
    for (int i = 0; i < 4; i++) begin
      checks++; if (ov[i] !== 1'b0) begin errors++; $display("FAIL bp_release[%0d]: got %b expected 0", i, ov[i]); end
    end
  endtask

  task automatic test_inverse;
    out_ready = 1'b0;
    start(MC, 1'b1);
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (ov[i] !== 1'b1) begin errors++; $display("FAIL inv_out_valid[%0d]: got %b expected 1", i, ov[i]); end
      checks++; if (so[i] !== PT) begin errors++; $display("FAIL inv_result[%0d]: got %h expected %h", i, so[i], PT); end
    end
    release_out();
  endtask

  task automatic test_mode_latch;
    out_ready = 1'b0;
    start(PT, 1'b0);
    repeat (4) begin in_inverse = ~in_inverse; tick(); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (so[i] !== MC) begin errors++; $display("FAIL latch_fwd[%0d]: got %h expected %h", i, so[i], MC); end
    end
    release_out();
    start(MC, 1'b1);
    repeat (4) begin in_inverse = ~in_inverse; tick(); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (so[i] !== PT) begin errors++; $display("FAIL latch_inv[%0d]: got %h expected %h", i, so[i], PT); end
    end
    release_out();
    start(PT, 1'b1);
    repeat (4) tick();
    checks++; if (so[3] !== MC) begin errors++; $display("FAIL inv_disabled: got %h expected %h", so[3], MC); end
    checks++; if (ov[3] !== 1'b1) begin errors++; $display("FAIL inv_disabled_valid: got %b expected 1", ov[3]); end
    release_out();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    start(PT, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (ov[i] !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid[%0d]: got %b expected 0", i, ov[i]); end
      checks++; if (so[i] !== 128'h0) begin errors++; $display("FAIL mid_reset_state_out[%0d]: got %h expected 0", i, so[i]); end
      checks++; if (bz[i] !== 1'b0) begin errors++; $display("FAIL mid_reset_busy[%0d]: got %b expected 0", i, bz[i]); end
    end
    rst_n = 1'b1;
    tick();
    start(PT, 1'b0);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (ov[i] !== 1'b1) begin errors++; $display("FAIL post_reset_valid[%0d]: got %b expected 1", i, ov[i]); end
      checks++; if (so[i] !== MC) begin errors++; $display("FAIL post_reset_result[%0d]: got %h expected %h", i, so[i], MC); end
    end
    release_out();
  endtask

  task automatic test_back_to_back;
    int   last_acc [4];
    int   nacc [4];
    logic will [4];
    for (int i = 0; i < 4; i++) begin last_acc[i] = -1; nacc[i] = 0; end
    out_ready = 1'b1; state_in = PT; in_inverse = 1'b0; in_valid = 1'b1;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) will[i] = ir[i];
      tick();
      for (int i = 0; i < 4; i++) begin
        if (will[i]) begin
          if (last_acc[i] >= 0) begin
            checks++;
            if (n - last_acc[i] != lat[i] + 2) begin
              errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, n - last_acc[i], lat[i] + 2);
            end
          end
          last_acc[i] = n;
          nacc[i]++;
        end
        if (ov[i] === 1'b1) begin
          checks++; if (so[i] !== MC) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, so[i], MC); end
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (nacc[i] < 3) begin errors++; $display("FAIL b2b_accepts[%0d]: got %0d expected at least 3", i, nacc[i]); end
    end
    repeat (8) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_backpressure();
    test_inverse();
    test_mode_latch();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
